// File: rtl/demux1to32_deser_if.sv
// rtl/demux1to32_deser_if.sv - strobe/select/data bus and word outputs of the 1:32 deserializer
interface demux1to32_deser_if #(
  parameter int SEL_W = 5,
  parameter int N     = 32
);
  logic [SEL_W-1:0] S;
  logic             D;
  logic             D_valid;
  logic             clear;
  logic [N-1:0]     Y;
  logic [N-1:0]     written;
  logic             word_valid;
  logic             overrun;

  modport master (
    output S, D, D_valid, clear,
    input  Y, written, word_valid, overrun
  );

  modport slave (
    input  S, D, D_valid, clear,
    output Y, written, word_valid, overrun
  );
endinterface

// File: rtl/demux1to32_deser.sv
// rtl/demux1to32_deser.sv - 1:32 bit demux deserializer; optional DEMUX_AUTO_INC_EN uses an internal pointer instead of S
module demux1to32_deser #(
  parameter int SEL_W = 5,
  parameter int N     = 32
) (
  input  logic              clk,
  input  logic              rst,
  demux1to32_deser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t           r_state;
  logic [N-1:0]     r_asm;
  logic [N-1:0]     r_written;
  logic [N-1:0]     r_y;
  logic             r_word_valid;
  logic             r_overrun;

  logic [SEL_W-1:0] w_sel;
  logic [N-1:0]     w_onehot;
  logic [N-1:0]     w_written_next;
  logic [N-1:0]     w_asm_merged;
  logic             w_complete;
  logic             w_dup;

`ifdef DEMUX_AUTO_INC_EN
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_unused_s;

  assign w_sel      = r_ptr;
  assign w_unused_s = bus.S;

  // Destination pointer: advances per accepted bit, wraps naturally since N == 2**SEL_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (bus.clear) begin
      r_ptr <= '0;
    end else if (bus.D_valid) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end
`else
  assign w_sel = bus.S;
`endif

  assign w_onehot       = {{(N-1){1'b0}}, 1'b1} << w_sel;
  assign w_written_next = r_written | w_onehot;
  assign w_complete     = &w_written_next;
  assign w_dup          = |(r_written & w_onehot);

  // Assembly word with the incoming bit already placed, so completion publishes it in the same edge
  always_comb begin
    w_asm_merged        = r_asm;
    w_asm_merged[w_sel] = bus.D;
  end

  // Frame FSM: collects bits, publishes Y with a one-cycle pulse, clear beats any concurrent write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_asm        <= '0;
      r_written    <= '0;
      r_y          <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (bus.clear) begin
      r_state      <= IDLE;
      r_asm        <= '0;
      r_written    <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (bus.D_valid) begin
      if (w_dup) begin
        r_overrun <= 1'b1;
      end
      if (w_complete) begin
        r_y          <= w_asm_merged;
        r_asm        <= '0;
        r_written    <= '0;
        r_word_valid <= 1'b1;
        r_state      <= DONE;
      end else begin
        r_asm        <= w_asm_merged;
        r_written    <= w_written_next;
        r_word_valid <= 1'b0;
        r_state      <= FILL;
      end
    end else begin
      r_word_valid <= 1'b0;
      if (r_state == DONE) begin
        r_state <= IDLE;
      end
    end
  end

  assign bus.Y          = r_y;
  assign bus.written    = r_written;
  assign bus.word_valid = r_word_valid;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_demux1to32_deser.sv
// tb/tb_demux1to32_deser.sv - randomized and directed bench for demux1to32_deser against a frame-level model
module tb_demux1to32_deser;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux1to32_deser_if #(.SEL_W(5), .N(N)) bus ();

  demux1to32_deser #(.SEL_W(5), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Frame-level model: which positions have arrived, their values, and the published word
  bit          m_seen [N];
  bit          m_val  [N];
  int          m_cnt;
  logic [31:0] m_y;
  bit          m_wv;
  bit          m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_flush();
    for (int i = 0; i < N; i++) begin
      m_seen[i] = 1'b0;
      m_val[i]  = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic model_reset();
    model_flush();
    m_y   = '0;
    m_wv  = 1'b0;
    m_ovr = 1'b0;
  endtask

  function automatic logic [31:0] pack_seen();
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) if (m_seen[i]) r = r + (32'd1 << i);
    return r;
  endfunction

  task automatic model_step(input int s, input bit d, input bit v, input bit c);
    m_wv = 1'b0;
    if (c) begin
      model_flush();
      m_ovr = 1'b0;
    end else if (v) begin
      if (m_seen[s]) m_ovr = 1'b1;
      else begin
        m_seen[s] = 1'b1;
        m_cnt++;
      end
      m_val[s] = d;
      if (m_cnt == N) begin
        m_y = '0;
        for (int i = 0; i < N; i++) if (m_val[i]) m_y = m_y + (32'd1 << i);
        m_wv = 1'b1;
        model_flush();
      end
    end
  endtask

  task automatic compare_all();
    check("Y", bus.Y, m_y);
    check("written", bus.written, pack_seen());
    check("word_valid", {31'd0, bus.word_valid}, {31'd0, m_wv});
    check("overrun", {31'd0, bus.overrun}, {31'd0, m_ovr});
  endtask

  task automatic cyc(input int s, input bit d, input bit v, input bit c);
    bus.S       = s[4:0];
    bus.D       = d;
    bus.D_valid = v;
    bus.clear   = c;
    @(posedge clk);
    model_step(s, d, v, c);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] word;
  int          order [N];
  int          pulses;
  int          pulse_at [$];

  initial begin
    bus.S = '0; bus.D = 1'b0; bus.D_valid = 1'b0; bus.clear = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // Sequential fill
    word = 32'hA5C3_0F96;
    for (int i = 0; i < N; i++) cyc(i, word[i], 1'b1, 1'b0);
    check("seq_Y", bus.Y, 32'hA5C3_0F96);
    check("seq_wv", {31'd0, bus.word_valid}, 32'd1);
    idle();
    check("seq_wv_drop", {31'd0, bus.word_valid}, 32'd0);

    // Reverse order fill
    word = 32'h8000_0001;
    for (int i = N - 1; i >= 0; i--) cyc(i, word[i], 1'b1, 1'b0);
    check("rev_Y", bus.Y, 32'h8000_0001);
    check("rev_ovr", {31'd0, bus.overrun}, 32'd0);
    idle();

    // Duplicate write, last write wins, overrun sticky
    cyc(5, 1'b1, 1'b1, 1'b0);
    cyc(5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) if (i != 5) cyc(i, 1'b0, 1'b1, 1'b0);
    check("dup_Y", bus.Y, 32'h0);
    check("dup_ovr", {31'd0, bus.overrun}, 32'd1);
    repeat (3) idle();
    check("dup_ovr_sticky", {31'd0, bus.overrun}, 32'd1);

    // Clear together with a strobe mid-frame
    cyc(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) cyc(i, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(i, 1'b0, 1'b1, 1'b0);
    cyc(10, 1'b0, 1'b1, 1'b1);
    check("clr_written", bus.written, 32'h0);
    check("clr_ovr", {31'd0, bus.overrun}, 32'd0);
    check("clr_Y_kept", bus.Y, 32'hFFFF_FFFF);
    word = $urandom;
    for (int i = 0; i < N; i++) cyc(i, word[i], 1'b1, 1'b0);
    check("clr_refill_Y", bus.Y, word);

    // Clear beats a completing write
    for (int i = 0; i < N - 1; i++) cyc(i, 1'b1, 1'b1, 1'b0);
    cyc(N - 1, 1'b1, 1'b1, 1'b1);
    check("clr_vs_done_wv", {31'd0, bus.word_valid}, 32'd0);
    check("clr_vs_done_Y", bus.Y, word);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 7; i++) cyc(i, 1'b1, 1'b1, 1'b0);
    bus.D_valid = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // Back-to-back frames, no bubble
    pulses = 0;
    for (int k = 1; k <= 2 * N; k++) begin
      cyc((k - 1) % N, (k <= N), 1'b1, 1'b0);
      if (bus.word_valid) begin
        pulses++;
        pulse_at.push_back(k);
        check("b2b_Y", bus.Y, (k <= N) ? 32'hFFFF_FFFF : 32'h0);
      end
    end
    check("b2b_pulses", pulses, 2);
    if (pulse_at.size() == 2) begin
      check("b2b_first_at", pulse_at[0], 32);
      check("b2b_second_at", pulse_at[1], 64);
    end else begin
      check("b2b_pulse_count_for_pos", pulse_at.size(), 2);
    end
    idle();

    // Random permutation frames with random gaps
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < N; i++) order[i] = i;
      for (int i = N - 1; i > 0; i--) begin
        int j = $urandom_range(i, 0);
        int t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3, 0) == 0) idle();
        cyc(order[i], $urandom_range(1, 0), 1'b1, 1'b0);
      end
    end

    // Free-running random traffic: duplicates, clears and collisions
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(N - 1, 0), $urandom_range(1, 0),
          $urandom_range(3, 0) != 0, $urandom_range(59, 0) == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
